// File: rtl/sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_responder_pkg
// Shared imager SRAM pin-bus definitions: default bus widths and the
// cycle-class encoding used by the frame-buffer initiators and the responder.
// -----------------------------------------------------------------------------
package sram_responder_pkg;

  localparam int SRAM_DATA_WIDTH     = 16;
  localparam int SRAM_ADDR_WIDTH     = 21;
  localparam int SRAM_MEM_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    CYC_IDLE  = 2'd0,
    CYC_READ  = 2'd1,
    CYC_WRITE = 2'd2
  } cycle_class_e;

  // Classify one sampled pin cycle; oeb does not affect the class.
  function automatic cycle_class_e classify_cycle(input logic ceb, input logic web);
    if (ceb)  return CYC_IDLE;
    if (!web) return CYC_WRITE;
    return CYC_READ;
  endfunction

endpackage

// File: rtl/sram_responder_array.sv
// -----------------------------------------------------------------------------
// sram_responder_array
// True dual-port synchronous RAM backing the SRAM responder.
//   Port A (front door): a_we_i/a_re_i/a_addr_i/a_wdata_i -> a_rdata_o
//   Port B (back door) : b_we_i/b_re_i/b_addr_i/b_wdata_i -> b_rdata_o
// Both read ports are registered and hold their value when not reading.
// Port A is write-first; a port-A write beats a port-B write to the same word.
// clk/reset: single clock, asynchronous active-high reset of the read registers.
// -----------------------------------------------------------------------------
module sram_responder_array #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_we_i,
  input  logic          a_re_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_we_i,
  input  logic          b_re_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic [DW-1:0] b_rdata_o
);

  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  // NOTE: the storage array has no reset so it maps onto RAM macros and keeps
  // its contents across a reset; only the read registers below are reset.
  always_ff @(posedge clk) begin
    if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    // Last non-blocking write to the same word wins, giving port A priority.
    if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
  end

  // Port B samples the pre-edge contents, so a concurrent port-A write to the
  // same word is not visible until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re_i) a_rdata_q <= a_we_i ? a_wdata_i : mem_q[a_addr_i];
      if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Responds to the 16-bit asynchronous-SRAM pin interface from an on-chip
// dual-port array, with a back-door port for preload and inspection.
// Ports:
//   clk, reset            - SRAM clock, asynchronous active-high reset
//   addr, ceb, web, oeb   - pin address and active-low strobes
//   ram_databus           - shared bidirectional data bus
//   bd_en/bd_we/bd_addr/bd_wdata -> bd_rdata/bd_rvalid  - back-door access
//   contention_err        - sticky: oeb and web both low in an enabled cycle
//   rd_count, wr_count    - front-door read/write cycle counters
// Build option: define SRAM_RESPONDER_STATS_EN to enable the counters;
// otherwise they are tied to zero.
// -----------------------------------------------------------------------------
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = SRAM_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = SRAM_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SRAM_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic                      ceb,
  input  logic                      web,
  input  logic                      oeb,
  inout  wire  [DATA_WIDTH-1:0]     ram_databus,
  input  logic                      bd_en,
  input  logic                      bd_we,
  input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]     bd_wdata,
  output logic [DATA_WIDTH-1:0]     bd_rdata,
  output logic                      bd_rvalid,
  output logic                      contention_err,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
);

  cycle_class_e              cyc;
  logic                      fd_we;
  logic                      fd_re;
  logic                      drive_en;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     rd_q;
  logic                      bd_rvalid_q;
  logic                      contention_q;
  logic                      unused_addr;

  assign cyc   = classify_cycle(ceb, web);
  assign fd_we = (cyc == CYC_WRITE);
  assign fd_re = (cyc == CYC_READ);

  // Upper address bits are ignored: the array aliases modulo its depth.
  assign mem_addr    = addr[MEM_ADDR_WIDTH-1:0];
  assign unused_addr = ^addr;

  // Output enable is combinational from the live pins, like a real async SRAM;
  // a write cycle with oeb low never drives, avoiding a fight with the initiator.
  assign drive_en    = !reset && fd_re && !oeb;
  assign ram_databus = drive_en ? rd_q : {DATA_WIDTH{1'bz}};

  sram_responder_array #(
    .AW (MEM_ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .a_we_i    (fd_we),
    .a_re_i    (fd_re),
    .a_addr_i  (mem_addr),
    .a_wdata_i (ram_databus),
    .a_rdata_o (rd_q),
    .b_we_i    (bd_en && bd_we),
    .b_re_i    (bd_en && !bd_we),
    .b_addr_i  (bd_addr),
    .b_wdata_i (bd_wdata),
    .b_rdata_o (bd_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd_rvalid_q  <= 1'b0;
      contention_q <= 1'b0;
    end else begin
      bd_rvalid_q <= bd_en && !bd_we;
      if (fd_we && !oeb) contention_q <= 1'b1;
    end
  end

  assign bd_rvalid      = bd_rvalid_q;
  assign contention_err = contention_q;

`ifdef SRAM_RESPONDER_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Free-running counters; wrap at 2^32.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (fd_re) rd_count_d = rd_count_q + 32'd1;
    if (fd_we) wr_count_d = wr_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Self-checking bench for sram_responder: a table of per-cycle pin/back-door
// stimulus with the outputs expected during that cycle, followed by directed
// sequences for contention and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  localparam int AW  = 21;
  localparam int MAW = 16;
  localparam int DW  = 16;

  localparam logic [1:0] IDL = 2'd0;  // ceb=1
  localparam logic [1:0] RD  = 2'd1;  // ceb=0 web=1 oeb=0
  localparam logic [1:0] WR  = 2'd2;  // ceb=0 web=0 oeb=1
  localparam logic [1:0] BN  = 2'd0;
  localparam logic [1:0] BR  = 2'd1;
  localparam logic [1:0] BW  = 2'd2;

  typedef enum logic [1:0] {CK_NONE, CK_EQ, CK_NE} bus_chk_e;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [1:0]    bdop;
    logic [15:0]   bd_addr;
    logic [DW-1:0] bd_wdata;
    bus_chk_e      bus_chk;
    logic [DW-1:0] exp_bus;
    logic          bd_chk;
    logic          exp_rvalid;
    logic [DW-1:0] exp_bd;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  addr = '0;
  logic           ceb = 1'b1;
  logic           web = 1'b1;
  logic           oeb = 1'b1;
  wire  [DW-1:0]  ram_databus;
  logic [DW-1:0]  tb_dat = '0;
  logic           tb_drv;
  logic           bd_en = 1'b0;
  logic           bd_we = 1'b0;
  logic [MAW-1:0] bd_addr = '0;
  logic [DW-1:0]  bd_wdata = '0;
  logic [DW-1:0]  bd_rdata;
  logic           bd_rvalid;
  logic           contention_err;
  logic [31:0]    rd_count;
  logic [31:0]    wr_count;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs[23];

  // The initiator drives the bus exactly in write cycles.
  assign tb_drv      = !ceb && !web;
  assign ram_databus = tb_drv ? tb_dat : {DW{1'bz}};

  always #5 clk = ~clk;

  sram_responder dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .ceb            (ceb),
    .web            (web),
    .oeb            (oeb),
    .ram_databus    (ram_databus),
    .bd_en          (bd_en),
    .bd_we          (bd_we),
    .bd_addr        (bd_addr),
    .bd_wdata       (bd_wdata),
    .bd_rdata       (bd_rdata),
    .bd_rvalid      (bd_rvalid),
    .contention_err (contention_err),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    n_cmp++;
    if (act === bad) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want anything but 0x%0h (bus should be released)", name, act, bad);
    end
  endtask

  function automatic vec_t v(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [1:0] bdop, input logic [15:0] ba, input logic [DW-1:0] bwd,
                             input bus_chk_e bc, input logic [DW-1:0] eb,
                             input logic bdc, input logic erv, input logic [DW-1:0] ebd);
    vec_t r;
    r.op = op; r.addr = a; r.wdat = d; r.bdop = bdop; r.bd_addr = ba; r.bd_wdata = bwd;
    r.bus_chk = bc; r.exp_bus = eb; r.bd_chk = bdc; r.exp_rvalid = erv; r.exp_bd = ebd;
    return r;
  endfunction

  task automatic drive_pins(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr   = a;
    tb_dat = d;
    ceb    = (op == IDL);
    web    = (op != WR);
    oeb    = (op != RD);
  endtask

  task automatic drive_bd(input logic [1:0] bdop, input logic [15:0] ba, input logic [DW-1:0] bwd);
    bd_en    = (bdop != BN);
    bd_we    = (bdop == BW);
    bd_addr  = ba;
    bd_wdata = bwd;
  endtask

  task automatic check_counters(input string tag, input int exp_rd, input int exp_wr);
`ifdef SRAM_RESPONDER_STATS_EN
    check({tag, " rd_count"}, rd_count, exp_rd);
    check({tag, " wr_count"}, wr_count, exp_wr);
`else
    check({tag, " rd_count"}, rd_count, 32'd0 & exp_rd);
    check({tag, " wr_count"}, wr_count, 32'd0 & exp_wr);
`endif
  endtask

  initial begin
    // Each row is one clock cycle; expectations are what is visible during
    // that cycle, before the edge that samples the row's pins.
    vecs[0]  = v(IDL, 21'h0,     16'h0,    BW, 16'h0010, 16'h1234, CK_NONE, 16'h0,    1, 0, 16'h0);
    vecs[1]  = v(RD,  21'h10,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'h0000, 1, 0, 16'h0);
    vecs[2]  = v(RD,  21'h10,    16'h0,    BR, 16'h0010, 16'h0,    CK_EQ,   16'h1234, 1, 0, 16'h0);
    vecs[3]  = v(IDL, 21'h0,     16'h0,    BN, 16'h0,    16'h0,    CK_NE,   16'h1234, 1, 1, 16'h1234);
    vecs[4]  = v(IDL, 21'h0,     16'h0,    BN, 16'h0,    16'h0,    CK_NONE, 16'h0,    1, 0, 16'h0);
    vecs[5]  = v(WR,  21'hFF,    16'hBEEF, BN, 16'h0,    16'h0,    CK_NONE, 16'h0,    0, 0, 16'h0);
    vecs[6]  = v(RD,  21'hFF,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'h1234, 0, 0, 16'h0);
    vecs[7]  = v(RD,  21'hFF,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'hBEEF, 0, 0, 16'h0);
    vecs[8]  = v(WR,  21'h10005, 16'h5555, BN, 16'h0,    16'h0,    CK_NONE, 16'h0,    0, 0, 16'h0);
    vecs[9]  = v(IDL, 21'h0,     16'h0,    BR, 16'h0005, 16'h0,    CK_NONE, 16'h0,    0, 0, 16'h0);
    vecs[10] = v(IDL, 21'h0,     16'h0,    BN, 16'h0,    16'h0,    CK_NONE, 16'h0,    1, 1, 16'h5555);
    vecs[11] = v(WR,  21'h20,    16'h1111, BW, 16'h0020, 16'h2222, CK_NONE, 16'h0,    0, 0, 16'h0);
    vecs[12] = v(IDL, 21'h0,     16'h0,    BR, 16'h0020, 16'h0,    CK_NONE, 16'h0,    0, 0, 16'h0);
    vecs[13] = v(RD,  21'h20,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'hBEEF, 1, 1, 16'h1111);
    vecs[14] = v(RD,  21'h20,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'h1111, 0, 0, 16'h0);
    vecs[15] = v(WR,  21'h20,    16'h3333, BR, 16'h0020, 16'h0,    CK_NONE, 16'h0,    0, 0, 16'h0);
    vecs[16] = v(IDL, 21'h0,     16'h0,    BR, 16'h0020, 16'h0,    CK_NONE, 16'h0,    1, 1, 16'h1111);
    vecs[17] = v(IDL, 21'h0,     16'h0,    BN, 16'h0,    16'h0,    CK_NONE, 16'h0,    1, 1, 16'h3333);
    vecs[18] = v(WR,  21'h30,    16'hA5A5, BN, 16'h0,    16'h0,    CK_NONE, 16'h0,    0, 0, 16'h0);
    vecs[19] = v(RD,  21'h30,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'h1111, 0, 0, 16'h0);
    vecs[20] = v(RD,  21'hFF,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'hA5A5, 0, 0, 16'h0);
    vecs[21] = v(RD,  21'h10,    16'h0,    BN, 16'h0,    16'h0,    CK_EQ,   16'hBEEF, 0, 0, 16'h0);
    vecs[22] = v(IDL, 21'h0,     16'h0,    BN, 16'h0,    16'h0,    CK_NE,   16'h1234, 0, 0, 16'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset bd_rdata", bd_rdata, 16'h0);
    check("reset bd_rvalid", bd_rvalid, 1'b0);
    check("reset contention_err", contention_err, 1'b0);
    check_counters("reset", 0, 0);
    reset = 1'b0;

    // Table-driven main function
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive_pins(vecs[i].op, vecs[i].addr, vecs[i].wdat);
      drive_bd(vecs[i].bdop, vecs[i].bd_addr, vecs[i].bd_wdata);
      #1;
      if (vecs[i].bus_chk == CK_EQ) check($sformatf("vec%0d bus", i), ram_databus, vecs[i].exp_bus);
      if (vecs[i].bus_chk == CK_NE) check_ne($sformatf("vec%0d bus", i), ram_databus, vecs[i].exp_bus);
      if (vecs[i].bd_chk) begin
        check($sformatf("vec%0d bd_rvalid", i), bd_rvalid, vecs[i].exp_rvalid);
        if (vecs[i].exp_rvalid) check($sformatf("vec%0d bd_rdata", i), bd_rdata, vecs[i].exp_bd);
      end
    end
    @(negedge clk);
    drive_pins(IDL, '0, '0);
    drive_bd(BN, '0, '0);
    #1;
    check_counters("table", 9, 5);
    check("table contention_err", contention_err, 1'b0);

    // Contention: oeb and web both low; write happens, responder stays off the bus
    @(negedge clk);
    addr = 21'h40; tb_dat = 16'h00AA; ceb = 1'b0; web = 1'b0; oeb = 1'b0;
    #1;
    check("contention bus", ram_databus, 16'h00AA);
    check("contention flag before edge", contention_err, 1'b0);
    @(negedge clk);
    drive_pins(IDL, '0, '0);
    drive_bd(BR, 16'h0040, '0);
    #1;
    check("contention flag set", contention_err, 1'b1);
    @(negedge clk);
    drive_bd(BN, '0, '0);
    #1;
    check("contention bd_rvalid", bd_rvalid, 1'b1);
    check("contention bd_rdata", bd_rdata, 16'h00AA);
    repeat (2) @(negedge clk);
    check("contention flag sticky", contention_err, 1'b1);
    check_counters("contention", 9, 6);

    // Reset in the middle of a read burst
    @(negedge clk);
    drive_pins(RD, 21'h10, '0);
    @(negedge clk);
    #1;
    check("burst bus", ram_databus, 16'h1234);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_ne("reset bus released", ram_databus, 16'h1234);
    check("midreset contention_err", contention_err, 1'b0);
    check("midreset bd_rvalid", bd_rvalid, 1'b0);
    check("midreset bd_rdata", bd_rdata, 16'h0);
    check_counters("midreset", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_pins(RD, 21'hFF, '0);
    @(negedge clk);
    drive_pins(RD, 21'h30, '0);
    drive_bd(BR, 16'h0010, '0);
    #1;
    check("post-reset bus 0x00FF", ram_databus, 16'hBEEF);
    @(negedge clk);
    drive_pins(IDL, '0, '0);
    drive_bd(BN, '0, '0);
    #1;
    check_ne("post-reset bus idle", ram_databus, 16'hA5A5);
    check("post-reset bd_rvalid", bd_rvalid, 1'b1);
    check("post-reset bd_rdata 0x0010", bd_rdata, 16'h1234);
    check_counters("post-reset", 2, 0);

    @(negedge clk);
    drive_pins(RD, 21'h30, '0);
    @(negedge clk);
    #1;
    check("post-reset bus 0x0030", ram_databus, 16'hA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the 16-bit asynchronous-SRAM pin interface driven by the imager's frame-buffer initiators (rotate and similar): active-low `ceb`/`web`/`oeb`, an address bus and a shared bidirectional data bus. It backs the pins with an on-chip dual-port array so that frame-buffer blocks can run on boards without external SRAM and in closed-loop benches. A back-door port preloads and inspects memory contents.

## Interface
- `ADDR_WIDTH`, 21: width of the pin address bus.
- `MEM_ADDR_WIDTH`, 16: implemented depth is 2^MEM_ADDR_WIDTH words; must be ≤ ADDR_WIDTH.
- `DATA_WIDTH`, 16: word width; pin bus and back-door width.
- `clk`  in  1: single clock, the initiator's SRAM clock (clk2x domain).
- `reset`  in  1: asynchronous, active-high reset.
- `addr`  in  ADDR_WIDTH: pin address.
- `ceb`  in  1: chip enable, active low.
- `web`  in  1: write enable, active low.
- `oeb`  in  1: output enable, active low.
- `ram_databus`  inout  DATA_WIDTH: shared data bus.
- `bd_en`  in  1: back-door access strobe.
- `bd_we`  in  1: back-door write when high, read when low.
- `bd_addr`  in  MEM_ADDR_WIDTH: back-door address.
- `bd_wdata`  in  DATA_WIDTH: back-door write data.
- `bd_rdata`  out  DATA_WIDTH: back-door read data.
- `bd_rvalid`  out  1: one-cycle pulse, `bd_rdata` valid.
- `contention_err`  out  1: sticky; `oeb` and `web` both low in an enabled cycle.
- `rd_count`, `wr_count`  out  32 each: front-door read and write counters (see Configuration).

## Operation
- All pins are sampled at posedge `clk`. Cycle class: idle (`ceb`=1), write (`ceb`=0, `web`=0), read (`ceb`=0, `web`=1).
- Address decode uses `addr[MEM_ADDR_WIDTH-1:0]`. Upper bits are ignored, so addresses alias modulo depth. No error is raised.
- Write: array[addr] ← `ram_databus` sampled at the same edge. The initiator drives data in the same cycle as `web`=0.
- Read: `rd_q` ← array[addr] at the sampling edge. `rd_q` holds its value through idle and write cycles.
- Bus drive is combinational from the current pins, matching an asynchronous SRAM output enable:
  - `ram_databus` = `rd_q` when `ceb`=0, `oeb`=0 and `web`=1.
  - Otherwise the bus is high-Z.
- Write-then-read of the same address on consecutive cycles returns the new data; the write commits before the read edge.
- `oeb`=0 with `web`=0: the write is performed, the bus is not driven, and `contention_err` is set. It clears only on reset.
- Back door:
  - `bd_en`&`bd_we` writes the array.
  - `bd_en`&!`bd_we` reads, with `bd_rdata`/`bd_rvalid` one cycle later.
  - If a front-door write and a back-door write hit the same word in the same cycle, the front door wins.
  - A back-door read concurrent with a front-door write to the same word returns the old data.
- The array contents are not reset. A reset mid-operation clears `rd_q`, `bd_rdata`, `bd_rvalid`, `contention_err` and the counters; the array is untouched.

## Timing
- Reset values: `bd_rdata`=0, `bd_rvalid`=0, `contention_err`=0, `rd_count`=0, `wr_count`=0, `rd_q`=0. `ram_databus` is high-Z while `reset` is high.
- Read latency:
  - Address sampled at edge N.
  - Data is on the bus during cycle N+1 if `oeb`=0 then.
  - The initiator captures it at edge N+2.
- Back-to-back reads sustain one word per cycle. Alternating write/read sustains one access per cycle; no turnaround cycle is required by the responder.
- Counters increment at the edge that samples the cycle, wrap at 2^32, and do not saturate.

## Configuration
- `SRAM_RESPONDER_STATS_EN` defined: `rd_count` and `wr_count` are live and count read and write cycles respectively.
- Undefined: both ports are tied to 0 and the counter logic is absent. `contention_err` is always present.

## Structure
- Shared package (imager SRAM defs): pin-bus constants such as `DATA_WIDTH`=16 and the cycle-class encodings (IDLE/READ/WRITE), reused by initiators.
- One sub-module, `sram_responder_array`: a true dual-port synchronous RAM (port A front door, port B back door) with registered read on both ports and write-first on port A.
- The top level holds pin decode, the tristate, the contention flag and the counters.

## Test plan
- Back-door write 0x1234 to 0x0010, then pin read of 0x0010 with `oeb`=0 the next cycle → bus = 0x1234 in cycle N+1; `bd` read of 0x0010 → `bd_rdata`=0x1234 with `bd_rvalid` high for one cycle.
- Pin write 0xBEEF at 0x00FF, then read of 0x00FF on the next cycle → 0xBEEF on the bus at the following cycle; `wr_count`=1, `rd_count`=1 with STATS_EN.
- Write 0x5555 at addr 0x10005 with MEM_ADDR_WIDTH=16 → back-door read of 0x0005 returns 0x5555.
- `ceb`=0, `web`=0, `oeb`=0 with data 0x00AA → array updated to 0x00AA, bus not driven by the responder, `contention_err`=1 until reset.
- Same-cycle front-door write 0x1111 and back-door write 0x2222 to 0x0020 → later read returns 0x1111.
- Assert `reset` during a read burst → bus high-Z immediately, counters and flag read 0, and previously written words are intact after release.
